riscv_mem_arbiter: RTL
======================

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, max consecutive MA grants while IF waits (guard build only).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports if_req  input  1, if_addr  input  XLEN  (fetch read request).
REQ-006 SHALL have ports if_gnt  output  1, if_rvalid  output  1, if_rdata  output  XLEN  (fetch grant/response).
REQ-007 SHALL have ports ma_req  input  1, ma_we  input  1, ma_addr  input  XLEN, ma_wdata  input  XLEN  (memory-access request).
REQ-008 SHALL have ports ma_gnt  output  1, ma_rvalid  output  1, ma_rdata  output  XLEN  (memory-access grant/response).
REQ-009 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  XLEN, mem_wdata  output  XLEN  (shared single-port memory request).
REQ-010 SHALL have ports mem_ack  input  1, mem_rdata  input  XLEN  (memory completion, rdata valid with ack).
REQ-011 SHALL have port busy  output  1  high while a transaction is outstanding.

Function
REQ-012 SHALL implement FSM states IDLE, OWN_IF, OWN_MA; exactly one transaction outstanding at any time.
REQ-013 In IDLE, gnt SHALL be combinational: ma_req -> ma_gnt=1; else if_req -> if_gnt=1; never both in one cycle.
REQ-014 On grant at edge T, the arbiter SHALL latch addr/we/wdata (we=0 for IF) and enter OWN_x; mem_req SHALL be high from T+1 until the ack cycle inclusive.
REQ-015 mem_addr/mem_we/mem_wdata SHALL be stable while mem_req is high; mem_we/mem_wdata SHALL be 0 when mem_req is low.
REQ-016 mem_ack SHALL be honoured only while mem_req is high; ack in the first mem_req cycle is legal; ack while mem_req is low SHALL be ignored.
REQ-017 On the ack edge the FSM SHALL return to IDLE and, on the next cycle, pulse owner's rvalid for exactly one cycle with rdata = mem_rdata captured at ack.
REQ-018 Writes SHALL also produce a ma_rvalid completion pulse; ma_rdata then carries captured mem_rdata (don't-care to user).
REQ-019 A new grant SHALL be possible in the IDLE cycle coinciding with the previous rvalid pulse (min 3 cycles per transaction with zero-wait ack).
REQ-020 rdata outputs SHALL hold last value between pulses; the non-owner's rvalid SHALL stay 0.
REQ-021 Requests dropped before grant SHALL be forgotten; requests in OWN_x SHALL wait (gnt=0) without corruption of the outstanding transaction.
REQ-022 busy SHALL equal (state != IDLE).

Reset
REQ-023 rst low SHALL asynchronously force state IDLE and all outputs, latched address/data, and starvation counter to 0.
REQ-024 Reset mid-transaction SHALL abandon it with no rvalid pulse after release; first grant possible in the first cycle after rst deasserts.

Configuration
REQ-025 Macro RISCV_ARB_STARVE_GUARD_EN SHALL compile in the starvation guard; without it, arbitration is strict MA priority and STARVE_MAX is unused.
REQ-026 With the macro: counter increments on each MA grant while if_req=1, clears on IF grant or on MA grant with if_req=0, saturates at STARVE_MAX.
REQ-027 With the macro: in IDLE with counter==STARVE_MAX and if_req=1, IF SHALL be granted even if ma_req=1.

Verification
REQ-028 IF read addr 0x100, mem_ack in first mem_req cycle, mem_rdata 0x00000013 -> if_gnt at T, mem_req at T+1 only, if_rvalid at T+2 with if_rdata 0x00000013.
REQ-029 Simultaneous if_req and ma_req (write 0x200<-0xDEADBEEF) -> ma_gnt first, mem_we=1 mem_wdata 0xDEADBEEF, then if_gnt after ma_rvalid cycle.
REQ-030 mem_ack delayed 3 cycles -> mem_req high 4 cycles, addr stable, busy high throughout, new requests see gnt=0.
REQ-031 Guard build, ma_req and if_req held high -> grant sequence MA x4 then IF, repeating; non-guard build -> MA only, if_gnt never asserted.
REQ-032 rst pulled low during OWN_MA with ack pending -> all outputs 0 immediately, no ma_rvalid after release, spurious mem_ack while idle ignored.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: fetch/memory-access arbiter onto one single-port memory, one transaction in flight.
// Define RISCV_ARB_STARVE_GUARD_EN to compile in the fetch starvation guard.
module riscv_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ma_req,
  input  logic            ma_we,
  input  logic [XLEN-1:0] ma_addr,
  input  logic [XLEN-1:0] ma_wdata,
  output logic            ma_gnt,
  output logic            ma_rvalid,
  output logic [XLEN-1:0] ma_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, OWN_IF, OWN_MA} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic we_q, idle, ack, force_if;
  assign idle      = state == IDLE;
  assign busy      = !idle;
  assign mem_req   = !idle;
  assign ack       = mem_req && mem_ack;
  assign mem_addr  = addr_q;
  assign mem_we    = mem_req && we_q;
  assign mem_wdata = mem_req ? wdata_q : '0;
  // grants are gated by reset so every output reads 0 while rst is low
  assign ma_gnt = rst && idle && ma_req && !force_if;
  assign if_gnt = rst && idle && if_req && !ma_gnt;
  always_comb begin
    state_nx = state;
    if (ma_gnt) state_nx = OWN_MA;
    else if (if_gnt) state_nx = OWN_IF;
    else if (ack) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      if_rvalid <= 1'b0;
      ma_rvalid <= 1'b0;
      if_rdata  <= '0;
      ma_rdata  <= '0;
    end else begin
      state     <= state_nx;
      if_rvalid <= ack && state == OWN_IF;
      ma_rvalid <= ack && state == OWN_MA;
      if (ack && state == OWN_IF) if_rdata <= mem_rdata;
      if (ack && state == OWN_MA) ma_rdata <= mem_rdata;
      if (ma_gnt) begin
        addr_q  <= ma_addr;
        we_q    <= ma_we;
        wdata_q <= ma_wdata;
      end else if (if_gnt) begin
        addr_q  <= if_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
      end
    end
  end
`ifdef RISCV_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt;
  assign force_if = if_req && cnt == CW'(STARVE_MAX);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (if_gnt || (ma_gnt && !if_req)) cnt <= '0;
    else if (ma_gnt && cnt != CW'(STARVE_MAX)) cnt <= cnt + 1'b1;
  end
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign force_if = 1'b0;
`endif
endmodule
